ula_multiciclo: RTL and testbench
=================================

# ula_multiciclo

Parametrised, registered successor to the 1-bit MIPS ULA: a WIDTH-bit ALU with a start/done handshake, condition flags and a multi-cycle unsigned multiply. It sits between the register file read ports and the write-back mux in the multi-cycle MIPS datapath. The control FSM issues `start`, then waits for `done`.

## Interface
- `WIDTH`, default 32: operand/result width. Legal values are 4 to 64.
- `clk`  in  1  system clock. Everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only when the block is ready, i.e. in IDLE or DONE.
- `ulaOp`  in  3  operation code.
- `in_A`, `in_B`  in  WIDTH each  operands. Captured on the accepting edge.
- `c_In`  in  1  carry-in. Used by ADD only.
- `Y`  out  WIDTH  result. Low half for MUL.
- `Y_hi`  out  WIDTH  high half of the MUL product. 0 for every other op.
- `zero`  out  1  high when `Y` == 0. For MUL, high when the full product == 0.
- `carry`  out  1  carry-out of ADD/SUB. 0 otherwise.
- `overflow`  out  1  signed overflow of ADD/SUB. 0 otherwise.
- `busy`  out  1  high in EXEC and MUL.
- `done`  out  1  one-cycle pulse when the result becomes valid.

## Operation
- Opcodes:
  - 000 AND
  - 001 OR
  - 010 ADD (A+B+c_In)
  - 011 MUL (unsigned)
  - 100 NOR
  - 101 reserved
  - 110 SUB (A+~B+1)
  - 111 SLT (signed)
- Reserved opcode 101: completes like a single-cycle op with `Y`=0 and every flag 0 except `zero`=1.
- FSM states are IDLE, EXEC, MUL and DONE.
  - IDLE/DONE + `start` with a non-MUL op goes to EXEC.
  - IDLE/DONE + `start` with op=MUL goes to MUL. The iteration counter clears to 0.
  - EXEC goes to DONE on the next edge. The result and flags are registered on that edge.
  - MUL iterates once per cycle. After WIDTH iterations it goes to DONE.
  - DONE goes to IDLE when `start`=0. If `start`=1 it re-accepts immediately (back-to-back).
- `start` while `busy` is ignored. Operands and op are not re-sampled.
- Outputs hold their last value in IDLE and DONE until the next result is registered.
- SUB carry follows MIPS style: `carry`=1 means no borrow (A ≥ B unsigned).
- `overflow` = (sign A == sign of the effective B) && (sign of sum != sign A).
- SLT: `Y` = {WIDTH-1 zeros, sum[WIDTH-1] ^ overflow} from A−B. `carry` and `overflow` are 0.
- MUL algorithm: shift-add over a 2·WIDTH accumulator. Each cycle, if multiplier LSB=1, add the multiplicand to the upper half, then shift the accumulator right 1 with the adder carry entering the top bit.
- Reset, including mid-MUL, does the following:
  - state returns to IDLE and the counter clears to 0;
  - `Y`, `Y_hi`, `carry`, `overflow`, `done` and `busy` go to 0, and `zero` goes to 1;
  - the in-flight operation is discarded and no `done` is produced for it.
- If `rst` and `start` are high on the same edge, reset wins.

## Timing
- A start accepted at edge N means the state is EXEC during cycle N..N+1.
- Non-MUL latency:
  - at edge N+1, `Y`/flags are valid and `done`=1 for exactly one cycle;
  - `busy`=1 for one cycle.
- MUL latency:
  - `busy`=1 for WIDTH cycles;
  - `Y`/`Y_hi`/`zero` update and `done` pulses at edge N+WIDTH+1;
  - WIDTH=8 gives `done` 9 cycles after acceptance.
- The fastest back-to-back issue is one non-MUL op every 2 cycles, because `start` is accepted in DONE.
- `done` and `busy` are never high together.

## Structure
- Package `ula_pkg` holds:
  - `ulaOp_t`, an enum over the 3-bit codes above, with 101 named `ULA_RSV`;
  - `state_t` (IDLE, EXEC, MUL, DONE).
- Sub-module `ula_mult`: the iterative shift-add core.
  - Parameter: `WIDTH`.
  - Ports: `clk`, `rst`, `load`, `mcand`, `mplier`, `product[2*WIDTH-1:0]`, `last`.
  - `last` is high on the final iteration.
- The top level contains the FSM, the combinational ALU for the single-cycle ops, the output registers and the flag logic.

## Test plan
All scenarios use WIDTH=8.
- ADD, A=0x7F, B=0x01, c_In=0, then c_In=1 → `Y`=0x80, `overflow`=1, `carry`=0 (then `Y`=0x81). `done` 1 cycle after start.
- SUB, A=0x05, B=0x05, then A=0x03, B=0x05 → first `Y`=0x00, `zero`=1, `carry`=1. Second `Y`=0xFE, `carry`=0. SLT with A=0xFE(−2), B=0x01 → `Y`=0x01.
- MUL, A=0xFF, B=0xFF → `busy` high for 8 cycles, `done` at cycle 9, `Y_hi`=0xFE, `Y`=0x01. MUL with A=0, B=0x5A → `zero`=1.
- AND/OR/NOR back-to-back with A=0xF0, B=0x3C, `start` held high → results 0x30, 0xFC, 0x03 on consecutive `done` pulses every 2 cycles.
- `start` with op=ADD pulsed during cycle 4 of a MUL → ignored. MUL result is correct and only one `done` appears.
- `rst` asserted at cycle 5 of a MUL → next cycle all outputs are 0 except `zero`=1, state is IDLE, and no `done` appears. A fresh ADD then completes normally.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared types for the multi-cycle ALU: operation codes and controller states.
package ula_pkg;

  typedef enum logic [2:0] {
    ULA_AND = 3'b000,
    ULA_OR  = 3'b001,
    ULA_ADD = 3'b010,
    ULA_MUL = 3'b011,
    ULA_NOR = 3'b100,
    ULA_RSV = 3'b101,
    ULA_SUB = 3'b110,
    ULA_SLT = 3'b111
  } ulaOp_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    DONE
  } state_t;

endpackage

// File: rtl/ula_mult.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle over a
// 2*WIDTH accumulator whose low half starts out holding the multiplier.
module ula_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q;
  logic [CW-1:0]    cnt;
  logic             running;
  logic [WIDTH:0]   partial;

  // Adder carry lands in bit WIDTH and is shifted into the accumulator MSB.
  assign partial = product[0] ? ({1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q})
                              : {1'b0, product[2*WIDTH-1:WIDTH]};
  assign last    = running && (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      product <= '0;
      mcand_q <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      product <= {{WIDTH{1'b0}}, mplier};
      mcand_q <= mcand;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      product <= {partial, product[WIDTH-1:1]};
      cnt     <= cnt + 1'b1;
      if (last) running <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Registered WIDTH-bit ALU with start/done handshake, condition flags and a
// multi-cycle unsigned multiply for the multi-cycle MIPS datapath.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ulaOp,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             c_In,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  state_t             state;
  ulaOp_t             op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               cin_q;
  logic               mul_wrap;
  logic               mul_load;
  logic [2*WIDTH-1:0] product;
  logic               last;

  logic               sub_op;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic               ovf_raw;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c, alu_v;

  assign mul_load = (state == IDLE || state == DONE) && start && (ulaOp_t'(ulaOp) == ULA_MUL);

  ula_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .mcand   (in_A),
    .mplier  (in_B),
    .product (product),
    .last    (last)
  );

  assign sub_op  = (op_q == ULA_SUB) || (op_q == ULA_SLT);
  assign b_eff   = sub_op ? ~b_q : b_q;
  assign sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (sub_op | cin_q)};
  assign ovf_raw = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_q)
      ULA_AND: alu_y = a_q & b_q;
      ULA_OR:  alu_y = a_q | b_q;
      ULA_NOR: alu_y = ~(a_q | b_q);
      ULA_ADD, ULA_SUB: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = ovf_raw;
      end
      ULA_SLT: alu_y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
      default: alu_y = '0;
    endcase
  end

  // The MUL state spends one extra cycle after the final iteration with busy
  // low, so the finished product is registered a cycle after the core settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= ULA_AND;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      mul_wrap <= 1'b0;
      Y        <= '0;
      Y_hi     <= '0;
      zero     <= 1'b1;
      carry    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_q     <= ulaOp_t'(ulaOp);
            a_q      <= in_A;
            b_q      <= in_B;
            cin_q    <= c_In;
            busy     <= 1'b1;
            mul_wrap <= 1'b0;
            state    <= (ulaOp_t'(ulaOp) == ULA_MUL) ? MUL : EXEC;
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          Y        <= alu_y;
          Y_hi     <= '0;
          zero     <= (alu_y == '0);
          carry    <= alu_c;
          overflow <= alu_v;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        MUL: begin
          if (mul_wrap) begin
            Y        <= product[WIDTH-1:0];
            Y_hi     <= product[2*WIDTH-1:WIDTH];
            zero     <= (product == '0);
            carry    <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b1;
            mul_wrap <= 1'b0;
            state    <= DONE;
          end else if (last) begin
            busy     <= 1'b0;
            mul_wrap <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed self-checking bench for ula_multiciclo at WIDTH=8 with
// hand-computed expected results.
module tb_ula_multiciclo;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] ulaOp;
  logic [7:0] in_A, in_B;
  logic       c_In;
  logic [7:0] Y, Y_hi;
  logic       zero, carry, overflow, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  ula_multiciclo #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ulaOp    (ulaOp),
    .in_A     (in_A),
    .in_B     (in_B),
    .c_In     (c_In),
    .Y        (Y),
    .Y_hi     (Y_hi),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, then wait (bounded) for done; check latency and busy length.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input int exp_lat,
                       input int exp_busy);
    int cyc = 0;
    int bc  = 0;
    start = 1'b1; ulaOp = op; in_A = a; in_B = b; c_In = ci;
    tick();
    start = 1'b0;
    while (!done && cyc < 40) begin
      if (busy) bc++;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b1; ulaOp = 3'b010; in_A = 8'h11; in_B = 8'h22; c_In = 1'b0;
    tick();
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_Y", 64'(Y), 64'h0);
    check("rst_Y_hi", 64'(Y_hi), 64'h0);
    check("rst_zero", 64'(zero), 64'h1);
    check("rst_carry", 64'(carry), 64'h0);
    check("rst_ovf", 64'(overflow), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    tick();
    check("rst_start_ignored_busy", 64'(busy), 64'h0);

    // ADD with signed overflow, then with carry-in
    do_op("add1", 3'b010, 8'h7F, 8'h01, 1'b0, 1, 1);
    check("add1_Y", 64'(Y), 64'h80);
    check("add1_ovf", 64'(overflow), 64'h1);
    check("add1_carry", 64'(carry), 64'h0);
    check("add1_zero", 64'(zero), 64'h0);
    tick();
    check("add1_done_pulse", 64'(done), 64'h0);
    do_op("add2", 3'b010, 8'h7F, 8'h01, 1'b1, 1, 1);
    check("add2_Y", 64'(Y), 64'h81);
    check("add2_ovf", 64'(overflow), 64'h1);
    tick();

    // SUB equal operands, SUB with borrow, SLT signed
    do_op("sub1", 3'b110, 8'h05, 8'h05, 1'b0, 1, 1);
    check("sub1_Y", 64'(Y), 64'h00);
    check("sub1_zero", 64'(zero), 64'h1);
    check("sub1_carry", 64'(carry), 64'h1);
    check("sub1_ovf", 64'(overflow), 64'h0);
    tick();
    do_op("sub2", 3'b110, 8'h03, 8'h05, 1'b0, 1, 1);
    check("sub2_Y", 64'(Y), 64'hFE);
    check("sub2_carry", 64'(carry), 64'h0);
    check("sub2_zero", 64'(zero), 64'h0);
    tick();
    do_op("slt", 3'b111, 8'hFE, 8'h01, 1'b0, 1, 1);
    check("slt_Y", 64'(Y), 64'h01);
    check("slt_carry", 64'(carry), 64'h0);
    tick();
    do_op("rsv", 3'b101, 8'hAA, 8'h55, 1'b1, 1, 1);
    check("rsv_Y", 64'(Y), 64'h00);
    check("rsv_zero", 64'(zero), 64'h1);
    check("rsv_carry", 64'(carry), 64'h0);
    tick();

    // MUL 0xFF*0xFF = 0xFE01
    do_op("mul1", 3'b011, 8'hFF, 8'hFF, 1'b0, 9, 8);
    check("mul1_Y", 64'(Y), 64'h01);
    check("mul1_Y_hi", 64'(Y_hi), 64'hFE);
    check("mul1_zero", 64'(zero), 64'h0);
    tick();
    do_op("mul0", 3'b011, 8'h00, 8'h5A, 1'b0, 9, 8);
    check("mul0_Y", 64'(Y), 64'h00);
    check("mul0_Y_hi", 64'(Y_hi), 64'h00);
    check("mul0_zero", 64'(zero), 64'h1);
    tick();

    // AND / OR / NOR back-to-back with start held high
    start = 1'b1; ulaOp = 3'b000; in_A = 8'hF0; in_B = 8'h3C; c_In = 1'b0;
    tick();
    tick();
    check("b2b_and_done", 64'(done), 64'h1);
    check("b2b_and_Y", 64'(Y), 64'h30);
    ulaOp = 3'b001;
    tick();
    check("b2b_or_accept_done", 64'(done), 64'h0);
    check("b2b_or_accept_busy", 64'(busy), 64'h1);
    tick();
    check("b2b_or_done", 64'(done), 64'h1);
    check("b2b_or_Y", 64'(Y), 64'hFC);
    ulaOp = 3'b100;
    tick();
    tick();
    check("b2b_nor_done", 64'(done), 64'h1);
    check("b2b_nor_Y", 64'(Y), 64'h03);
    start = 1'b0;
    tick();
    tick();

    // start pulsed during cycle 4 of a MUL: 0x0D*0x0B = 0x008F
    start = 1'b1; ulaOp = 3'b011; in_A = 8'h0D; in_B = 8'h0B;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; ulaOp = 3'b010; in_A = 8'h01; in_B = 8'h01;
    tick();
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        n_done++;
        check("ign_mul_Y", 64'(Y), 64'h8F);
        check("ign_mul_Y_hi", 64'(Y_hi), 64'h00);
      end
      tick();
    end
    check("ign_done_count", 64'(n_done), 64'd1);

    // Reset in cycle 5 of a MUL discards it
    start = 1'b1; ulaOp = 3'b011; in_A = 8'hFF; in_B = 8'hFF;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_Y", 64'(Y), 64'h0);
    check("mrst_Y_hi", 64'(Y_hi), 64'h0);
    check("mrst_zero", 64'(zero), 64'h1);
    check("mrst_busy", 64'(busy), 64'h0);
    check("mrst_done", 64'(done), 64'h0);
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      if (done || busy) n_done++;
      tick();
    end
    check("mrst_no_activity", 64'(n_done), 64'd0);
    do_op("post_rst_add", 3'b010, 8'h02, 8'h03, 1'b0, 1, 1);
    check("post_rst_add_Y", 64'(Y), 64'h05);
    check("post_rst_add_zero", 64'(zero), 64'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
